// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: FSM state and grant encodings.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

  typedef enum logic {
    GntInst = 1'b0,
    GntData = 1'b1
  } grant_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side handshakes of mem_port_arbiter.
//   slave  : arbiter view (requests and memory response in; ready/data/memory request out)
//   master : environment view (requesters plus memory model)
interface mem_port_arbiter_if #(
  parameter int unsigned WORD_SIZE  = 16,
  parameter int unsigned ADDR_WIDTH = 16
);
  logic                  i_req;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic                  i_ready;
  logic [WORD_SIZE-1:0]  i_data;
  logic                  d_req;
  logic                  d_we;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [WORD_SIZE-1:0]  d_wdata;
  logic                  d_ready;
  logic [WORD_SIZE-1:0]  d_rdata;
  logic                  m_req;
  logic                  m_we;
  logic [ADDR_WIDTH-1:0] m_addr;
  logic [WORD_SIZE-1:0]  m_wdata;
  logic [WORD_SIZE-1:0]  m_rdata;
  logic                  m_ack;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
    output i_ready, i_data, d_ready, d_rdata, m_req, m_we, m_addr, m_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
    input  i_ready, i_data, d_ready, d_rdata, m_req, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/mem_port_arbiter_arb_pick.sv
// Combinational two-way round-robin picker.
//   i_req_i, d_req_i : pending requests
//   last_grant_i     : requester granted most recently
//   valid_o          : at least one request pending
//   winner_o         : chosen requester (meaningful only when valid_o)
module arb_pick
  import mem_port_arbiter_pkg::*;
(
  input  logic   i_req_i,
  input  logic   d_req_i,
  input  grant_e last_grant_i,
  output logic   valid_o,
  output grant_e winner_o
);

  always_comb begin
    valid_o  = i_req_i | d_req_i;
    winner_o = GntInst;
    if (i_req_i && d_req_i) begin
      // Contention: hand the port to whoever did not have it last.
      winner_o = (last_grant_i == GntInst) ? GntData : GntInst;
    end else if (d_req_i) begin
      winner_o = GntData;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access, one transaction at a time.
//   clk, reset_n : clock and asynchronous active-low reset
//   bus          : fetch/data request handshakes and the registered memory-side request
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned WORD_SIZE  = 16,
  parameter int unsigned ADDR_WIDTH = 16
) (
  input logic               clk,
  input logic               reset_n,
  mem_port_arbiter_if.slave bus
);

  state_e                state_q, state_d;
  grant_e                grant_q, grant_d;
  grant_e                last_grant_q, last_grant_d;
  logic                  m_req_q, m_req_d;
  logic                  m_we_q, m_we_d;
  logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
  logic [WORD_SIZE-1:0]  m_wdata_q, m_wdata_d;
  logic                  i_ready_q, i_ready_d;
  logic                  d_ready_q, d_ready_d;
  logic [WORD_SIZE-1:0]  i_data_q, i_data_d;
  logic [WORD_SIZE-1:0]  d_rdata_q, d_rdata_d;

  logic   pick_valid;
  grant_e pick_winner;

  arb_pick u_arb_pick (
    .i_req_i      (bus.i_req),
    .d_req_i      (bus.d_req),
    .last_grant_i (last_grant_q),
    .valid_o      (pick_valid),
    .winner_o     (pick_winner)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    m_req_d      = m_req_q;
    m_we_d       = m_we_q;
    m_addr_d     = m_addr_q;
    m_wdata_d    = m_wdata_q;
    i_data_d     = i_data_q;
    d_rdata_d    = d_rdata_q;
    // Ready is a pulse: only set on the edge into DONE, so it lives exactly one cycle.
    i_ready_d    = 1'b0;
    d_ready_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          grant_d      = pick_winner;
          last_grant_d = pick_winner;
          m_req_d      = 1'b1;
          m_addr_d     = (pick_winner == GntData) ? bus.d_addr : bus.i_addr;
          m_we_d       = (pick_winner == GntData) && bus.d_we;
          // Fetches leave the last write data on the bus untouched.
          m_wdata_d    = (pick_winner == GntData) ? bus.d_wdata : m_wdata_q;
          state_d      = StBusy;
        end
      end
      StBusy: begin
        if (bus.m_ack) begin
          m_req_d = 1'b0;
          m_we_d  = 1'b0;
          state_d = StDone;
          if (grant_q == GntInst) begin
            i_data_d  = bus.m_rdata;
            i_ready_d = 1'b1;
          end else begin
            d_ready_d = 1'b1;
            if (!m_we_q) begin
              d_rdata_d = bus.m_rdata;
            end
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      grant_q      <= GntInst;
      last_grant_q <= GntInst;
      m_req_q      <= 1'b0;
      m_we_q       <= 1'b0;
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
      i_ready_q    <= 1'b0;
      d_ready_q    <= 1'b0;
      i_data_q     <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      m_req_q      <= m_req_d;
      m_we_q       <= m_we_d;
      m_addr_q     <= m_addr_d;
      m_wdata_q    <= m_wdata_d;
      i_ready_q    <= i_ready_d;
      d_ready_q    <= d_ready_d;
      i_data_q     <= i_data_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign bus.m_req   = m_req_q;
  assign bus.m_we    = m_we_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_wdata = m_wdata_q;
  assign bus.i_ready = i_ready_q;
  assign bus.i_data  = i_data_q;
  assign bus.d_ready = d_ready_q;
  assign bus.d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  mem_port_arbiter_if #(.WORD_SIZE(16), .ADDR_WIDTH(16)) bus ();

  mem_port_arbiter #(.WORD_SIZE(16), .ADDR_WIDTH(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit          ir;
    bit          dr;
    logic [15:0] ia;
    logic [15:0] da;
    bit          dwe;
    logic [15:0] dwd;
    int          waits;
    logic [15:0] rd;
    bit          ewin;   // 0 = fetch, 1 = data
    logic [15:0] eaddr;
    bit          ewe;
    logic [15:0] ewd;
    logic [15:0] eidata;
    logic [15:0] edrdata;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    bus.i_req = 0; bus.i_addr = 0; bus.d_req = 0; bus.d_we = 0;
    bus.d_addr = 0; bus.d_wdata = 0; bus.m_rdata = 0; bus.m_ack = 0;
    reset_n = 0;
    @(negedge clk);
    @(negedge clk);
    check("rst_m_req", bus.m_req, 0);
    check("rst_m_we", bus.m_we, 0);
    check("rst_m_addr", bus.m_addr, 0);
    check("rst_m_wdata", bus.m_wdata, 0);
    check("rst_i_ready", bus.i_ready, 0);
    check("rst_d_ready", bus.d_ready, 0);
    check("rst_i_data", bus.i_data, 0);
    check("rst_d_rdata", bus.d_rdata, 0);
    reset_n = 1;
    @(negedge clk);
  endtask

  // Called at a negedge with the arbiter in IDLE. Presents requests, plays the memory
  // (acking after 'waits' wait cycles) and checks every cycle up to the return to IDLE.
  task automatic run_txn(input vec_t v, input bit keep, input bit ack_done);
    bus.i_req = v.ir; bus.i_addr = v.ia;
    bus.d_req = v.dr; bus.d_addr = v.da; bus.d_we = v.dwe; bus.d_wdata = v.dwd;
    bus.m_ack = 0;
    @(negedge clk);
    check("grant_m_req", bus.m_req, 1);
    check("grant_m_addr", bus.m_addr, v.eaddr);
    check("grant_m_we", bus.m_we, v.ewe);
    check("grant_m_wdata", bus.m_wdata, v.ewd);
    check("grant_no_ready", {bus.i_ready, bus.d_ready}, 0);
    for (int k = 0; k <= v.waits; k++) begin
      bus.m_ack   = (k == v.waits);
      bus.m_rdata = (k == v.waits) ? v.rd : ~v.rd;
      @(negedge clk);
      if (k < v.waits) begin
        check("busy_m_req", bus.m_req, 1);
        check("busy_m_addr", bus.m_addr, v.eaddr);
        check("busy_m_we", bus.m_we, v.ewe);
        check("busy_m_wdata", bus.m_wdata, v.ewd);
        check("busy_no_ready", {bus.i_ready, bus.d_ready}, 0);
      end
    end
    // DONE cycle
    bus.m_ack   = ack_done;
    bus.m_rdata = ~v.rd;
    if (!keep) begin
      if (v.ewin) bus.d_req = 0;
      else        bus.i_req = 0;
    end
    check("done_i_ready", bus.i_ready, !v.ewin);
    check("done_d_ready", bus.d_ready, v.ewin);
    check("done_m_req", bus.m_req, 0);
    check("done_m_we", bus.m_we, 0);
    check("done_i_data", bus.i_data, v.eidata);
    check("done_d_rdata", bus.d_rdata, v.edrdata);
    @(negedge clk);
    bus.m_ack = 0;
    check("idle_ready_low", {bus.i_ready, bus.d_ready}, 0);
    check("idle_m_req", bus.m_req, 0);
    check("idle_i_data", bus.i_data, v.eidata);
    check("idle_d_rdata", bus.d_rdata, v.edrdata);
  endtask

  function automatic vec_t mk(bit ir, bit dr, logic [15:0] ia, logic [15:0] da, bit dwe,
                              logic [15:0] dwd, int waits, logic [15:0] rd, bit ewin,
                              logic [15:0] eaddr, bit ewe, logic [15:0] ewd,
                              logic [15:0] eid, logic [15:0] edr);
    vec_t v;
    v.ir = ir; v.dr = dr; v.ia = ia; v.da = da; v.dwe = dwe; v.dwd = dwd;
    v.waits = waits; v.rd = rd; v.ewin = ewin; v.eaddr = eaddr; v.ewe = ewe;
    v.ewd = ewd; v.eidata = eid; v.edrdata = edr;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    vec_t v;
    // Reference model state for the random phase
    bit          last_g;
    bit          pi, pd;
    logic [15:0] ia, da, dwd, mod_wd, mod_id, mod_dr, rd;
    bit          dwe, win;

    // Sequence from reset: last grant = fetch, write data bus = 0.
    tbl[0] = mk(1, 0, 16'h0010, 16'h0000, 0, 16'h0000, 0, 16'hA5A5,
                0, 16'h0010, 0, 16'h0000, 16'hA5A5, 16'h0000);
    tbl[1] = mk(0, 1, 16'h0000, 16'h0020, 1, 16'h1234, 3, 16'hBEEF,
                1, 16'h0020, 1, 16'h1234, 16'hA5A5, 16'h0000);
    tbl[2] = mk(1, 1, 16'h0100, 16'h0200, 0, 16'h5555, 1, 16'h1111,
                0, 16'h0100, 0, 16'h1234, 16'h1111, 16'h0000);
    tbl[3] = mk(0, 1, 16'h0100, 16'h0200, 0, 16'h5555, 0, 16'h2222,
                1, 16'h0200, 0, 16'h5555, 16'h1111, 16'h2222);
    tbl[4] = mk(1, 0, 16'h0300, 16'h0200, 0, 16'h5555, 2, 16'h3333,
                0, 16'h0300, 0, 16'h5555, 16'h3333, 16'h2222);
    tbl[5] = mk(0, 1, 16'h0300, 16'h0400, 1, 16'h9999, 0, 16'h4444,
                1, 16'h0400, 1, 16'h9999, 16'h3333, 16'h2222);
    tbl[6] = mk(1, 1, 16'h0500, 16'h0600, 0, 16'h7777, 0, 16'h6666,
                0, 16'h0500, 0, 16'h9999, 16'h6666, 16'h2222);
    tbl[7] = mk(0, 1, 16'h0500, 16'h0600, 0, 16'h7777, 0, 16'h8888,
                1, 16'h0600, 0, 16'h7777, 16'h6666, 16'h8888);

    do_reset();
    for (int i = 0; i < 8; i++) run_txn(tbl[i], 0, 0);

    // Continuous contention from reset: D, I, D, I.
    do_reset();
    run_txn(mk(1, 1, 16'h1000, 16'h2000, 0, 16'h0000, 0, 16'hAAAA,
               1, 16'h2000, 0, 16'h0000, 16'h0000, 16'hAAAA), 1, 0);
    run_txn(mk(1, 1, 16'h1000, 16'h2000, 0, 16'h0000, 1, 16'hBBBB,
               0, 16'h1000, 0, 16'h0000, 16'hBBBB, 16'hAAAA), 1, 0);
    run_txn(mk(1, 1, 16'h1000, 16'h2000, 0, 16'h0000, 0, 16'hCCCC,
               1, 16'h2000, 0, 16'h0000, 16'hBBBB, 16'hCCCC), 1, 0);
    run_txn(mk(1, 1, 16'h1000, 16'h2000, 0, 16'h0000, 2, 16'hDDDD,
               0, 16'h1000, 0, 16'h0000, 16'hDDDD, 16'hCCCC), 1, 0);

    // m_ack during DONE and while IDLE is ignored.
    do_reset();
    run_txn(mk(1, 0, 16'h0010, 16'h0000, 0, 16'h0000, 0, 16'hA5A5,
               0, 16'h0010, 0, 16'h0000, 16'hA5A5, 16'h0000), 0, 1);
    bus.m_ack = 1; bus.m_rdata = 16'hFFFF;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("idle_ack_m_req", bus.m_req, 0);
      check("idle_ack_ready", {bus.i_ready, bus.d_ready}, 0);
      check("idle_ack_i_data", bus.i_data, 16'hA5A5);
      check("idle_ack_m_addr", bus.m_addr, 16'h0010);
    end
    bus.m_ack = 0;
    @(negedge clk);

    // Reset in the middle of a data read.
    do_reset();
    bus.d_req = 1; bus.d_addr = 16'h0030; bus.d_we = 0;
    @(negedge clk);
    check("abort_busy_m_req", bus.m_req, 1);
    #2 reset_n = 0;
    #1 check("abort_m_req_async", bus.m_req, 0);
    bus.d_req = 0; bus.m_ack = 1; bus.m_rdata = 16'h7E7E;
    @(negedge clk);
    @(negedge clk);
    check("abort_no_ready", {bus.i_ready, bus.d_ready}, 0);
    check("abort_d_rdata", bus.d_rdata, 0);
    reset_n = 1; bus.m_ack = 0;
    @(negedge clk);
    run_txn(mk(1, 1, 16'h0050, 16'h0060, 0, 16'h0000, 0, 16'h0F0F,
               1, 16'h0060, 0, 16'h0000, 16'h0000, 16'h0F0F), 0, 0);

    // Data request held past d_ready: second transaction samples the new address.
    do_reset();
    run_txn(mk(0, 1, 16'h0000, 16'h0040, 0, 16'h0000, 0, 16'h1357,
               1, 16'h0040, 0, 16'h0000, 16'h0000, 16'h1357), 1, 0);
    run_txn(mk(0, 1, 16'h0000, 16'h0044, 0, 16'h0000, 1, 16'h2468,
               1, 16'h0044, 0, 16'h0000, 16'h0000, 16'h2468), 0, 0);

    // Random traffic against a transaction-level model.
    do_reset();
    last_g = 0; pi = 0; pd = 0; mod_wd = 0; mod_id = 0; mod_dr = 0;
    ia = 0; da = 0; dwd = 0; dwe = 0;
    for (int n = 0; n < 60; n++) begin
      if (!pi && $urandom_range(0, 1) == 1) begin
        pi = 1; ia = 16'($urandom);
      end
      if (!pd && $urandom_range(0, 1) == 1) begin
        pd = 1; da = 16'($urandom); dwd = 16'($urandom); dwe = 1'($urandom);
      end
      if (!pi && !pd) begin
        pi = 1; ia = 16'($urandom);
      end
      win    = (pi && pd) ? !last_g : pd;
      last_g = win;
      rd     = 16'($urandom);
      if (win) mod_wd = dwd;
      if (!win)      mod_id = rd;
      else if (!dwe) mod_dr = rd;
      v = mk(pi, pd, ia, da, dwe, dwd, int'($urandom_range(0, 3)), rd,
             win, win ? da : ia, win && dwe, mod_wd, mod_id, mod_dr);
      run_txn(v, 0, 1'($urandom));
      if (win) pd = 0;
      else     pi = 0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
